// File: rtl/f1_race_ctrl.sv
// F1 start-lights sequencer: steps the lights FSM on, holds for a pseudo-random
// time, measures the driver's reaction and aborts cleanly on a jump start.
module f1_race_ctrl #(
  parameter int TICK_DIV   = 24,
  parameter int DELAY_UNIT = 16,
  parameter int RT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            react,
  input  logic            cmd_seq,
  input  logic            cmd_delay,
  output logic            fsm_en,
  output logic            fsm_trigger,
  output logic            lights_out,
  output logic            react_valid,
  output logic [RT_W-1:0] react_time,
  output logic            jump_start,
  output logic            busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(127 * DELAY_UNIT + 1);

  typedef enum logic [2:0] {IDLE, SEQ, HOLD, TIMING, ABORT} state_t;

  state_t          state, state_next;
  logic [6:0]      lfsr;
  logic [TW-1:0]   tick;
  logic [HW-1:0]   hold_cnt;
  logic [RT_W-1:0] rt_cnt;
  logic            tick_last;
  logic            hold_last;

  assign tick_last = (tick == TW'(TICK_DIV - 1));
  assign hold_last = (hold_cnt == HW'(1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A button press during SEQ or HOLD always wins, even on the final HOLD cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEQ;
      SEQ:     if (react) state_next = ABORT;
               else if (cmd_delay) state_next = HOLD;
      HOLD:    if (react) state_next = ABORT;
               else if (hold_last) state_next = TIMING;
      TIMING:  if (react) state_next = IDLE;
      ABORT:   if (!cmd_seq) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fsm_en      = 1'b0;
    fsm_trigger = 1'b0;
    lights_out  = 1'b0;
    react_valid = 1'b0;
    jump_start  = 1'b0;
    case (state)
      IDLE:    fsm_trigger = start;
      SEQ:     if (react) jump_start = 1'b1;
               else fsm_en = tick_last && !cmd_delay;
      HOLD:    if (react) jump_start = 1'b1;
               else begin
                 fsm_en     = hold_last;
                 lights_out = hold_last;
               end
      TIMING:  react_valid = react;
      ABORT:   fsm_en = cmd_seq;
      default: ;
    endcase
  end

  // The LFSR free-runs in every state so the hold time depends on when S8 is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= 7'h01;
      tick       <= '0;
      hold_cnt   <= '0;
      rt_cnt     <= '0;
      react_time <= '0;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      case (state)
        IDLE: if (start) tick <= '0;
        SEQ: begin
          tick <= tick_last ? '0 : tick + 1'b1;
          if (!react && cmd_delay) hold_cnt <= HW'(lfsr) * HW'(DELAY_UNIT);
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (!react && hold_last) rt_cnt <= RT_W'(1);
        end
        TIMING: begin
          if (rt_cnt != '1) rt_cnt <= rt_cnt + 1'b1;
          if (react) react_time <= rt_cnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_race_ctrl.sv
// Bench for f1_race_ctrl: a timestamp-based reference model checks every cycle,
// directed runs pin literal values, and a second instance checks saturation.
module tb_f1_race_ctrl;

  localparam int TICK = 4;
  localparam int DU   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, react = 1'b0;
  logic        start4 = 1'b0, react4 = 1'b0;
  logic        cmd_seq, cmd_delay, fsm_en, fsm_trigger, lights_out, react_valid, jump_start, busy;
  logic [15:0] react_time;
  logic        cmd_seq4, cmd_delay4, fsm_en4, fsm_trigger4, lights_out4, react_valid4, jump_start4, busy4;
  logic [3:0]  react_time4;
  logic [7:0]  data_out;
  int          ls, ls4;
  int          cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef enum int {M_IDLE, M_SEQ, M_HOLD, M_TIMING, M_ABORT} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_lfsr = 1, m_t0 = 0, m_hold_end = 0, m_lo = 0, m_v = 0, m_rt = 0;

  always #5 clk = ~clk;

  f1_race_ctrl #(.TICK_DIV(TICK), .DELAY_UNIT(DU), .RT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .react(react),
    .cmd_seq(cmd_seq), .cmd_delay(cmd_delay),
    .fsm_en(fsm_en), .fsm_trigger(fsm_trigger), .lights_out(lights_out),
    .react_valid(react_valid), .react_time(react_time),
    .jump_start(jump_start), .busy(busy)
  );

  f1_race_ctrl #(.TICK_DIV(TICK), .DELAY_UNIT(DU), .RT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start4), .react(react4),
    .cmd_seq(cmd_seq4), .cmd_delay(cmd_delay4),
    .fsm_en(fsm_en4), .fsm_trigger(fsm_trigger4), .lights_out(lights_out4),
    .react_valid(react_valid4), .react_time(react_time4),
    .jump_start(jump_start4), .busy(busy4)
  );

  // Lights FSMs: S0..S8, trigger forces S1, en steps and wraps S8 to S0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ls <= 0;
    else if (fsm_trigger) ls <= 1;
    else if (fsm_en && ls != 0) ls <= (ls == 8) ? 0 : ls + 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ls4 <= 0;
    else if (fsm_trigger4) ls4 <= 1;
    else if (fsm_en4 && ls4 != 0) ls4 <= (ls4 == 8) ? 0 : ls4 + 1;
  end

  assign cmd_seq    = (ls != 0);
  assign cmd_delay  = (ls == 8);
  assign cmd_seq4   = (ls4 != 0);
  assign cmd_delay4 = (ls4 == 8);
  always_comb data_out = 8'((9'h1 << ls) - 9'h1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #1;
    start = s;
    react = r;
  endtask

  task automatic doReset();
    start = 1'b0; react = 1'b0; start4 = 1'b0; react4 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: outputs follow from start time, hold deadline and lights-out time.
  always @(negedge clk) begin
    mode_t nxt;
    int    e_en, e_trig, e_lo, e_val, e_jump, rt_next;
    if (rst) begin
      m_mode = M_IDLE;
      m_lfsr = 1;
      m_rt   = 0;
      checkOutput("reset_outputs", {26'd0, fsm_en, fsm_trigger, lights_out, react_valid, jump_start, busy}, 0);
      checkOutput("reset_react_time", {16'd0, react_time}, 0);
    end else begin
      nxt = m_mode;
      e_en = 0; e_trig = 0; e_lo = 0; e_val = 0; e_jump = 0;
      rt_next = m_rt;
      case (m_mode)
        M_IDLE: if (start) begin e_trig = 1; m_t0 = cyc; nxt = M_SEQ; end
        M_SEQ: begin
          if (react) begin e_jump = 1; nxt = M_ABORT; end
          else if (ls == 8) begin
            m_v = m_lfsr;
            m_hold_end = cyc + m_lfsr * DU;
            nxt = M_HOLD;
          end else if ((cyc - m_t0) % TICK == 0) e_en = 1;
        end
        M_HOLD: begin
          if (react) begin e_jump = 1; nxt = M_ABORT; end
          else if (cyc == m_hold_end) begin
            e_en = 1; e_lo = 1; m_lo = cyc; nxt = M_TIMING;
          end
        end
        M_TIMING: if (react) begin
          e_val = 1;
          rt_next = (cyc - m_lo > 65535) ? 65535 : cyc - m_lo;
          nxt = M_IDLE;
        end
        M_ABORT: begin
          e_en = (ls != 0) ? 1 : 0;
          if (ls == 0) nxt = M_IDLE;
        end
        default: nxt = M_IDLE;
      endcase
      checkOutput("fsm_en", {31'd0, fsm_en}, e_en);
      checkOutput("fsm_trigger", {31'd0, fsm_trigger}, e_trig);
      checkOutput("lights_out", {31'd0, lights_out}, e_lo);
      checkOutput("react_valid", {31'd0, react_valid}, e_val);
      checkOutput("jump_start", {31'd0, jump_start}, e_jump);
      checkOutput("busy", {31'd0, busy}, (m_mode != M_IDLE) ? 1 : 0);
      checkOutput("react_time", {16'd0, react_time}, m_rt);
      m_mode = nxt;
      m_rt   = rt_next;
      m_lfsr = ((m_lfsr << 1) & 127) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
    end
  end

  initial begin
    int cnt, first_en, last_en, lo_cyc, n, bad;
    bit found, jumpy;
    logic s, r;

    doReset();
    cnt = 0;
    repeat (20) begin
      applyStimulus(0, 0);
      @(negedge clk);
      if (fsm_en || fsm_trigger || lights_out || react_valid || jump_start || busy) cnt++;
    end
    checkOutput("idle_activity", cnt, 0);

    doReset();
    repeat (4) applyStimulus(0, 0);
    applyStimulus(1, 0);
    @(negedge clk);
    checkOutput("trigger_cycle5", {31'd0, fsm_trigger}, 1);
    cnt = 0; first_en = -1; last_en = -1;
    for (int c = 6; c <= 33; c++) begin
      applyStimulus(0, 0);
      @(negedge clk);
      if (fsm_en) begin
        cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
    end
    checkOutput("seq_en_count", cnt, 7);
    checkOutput("seq_first_en", first_en, 9);
    checkOutput("seq_last_en", last_en, 33);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("lights_full", {24'd0, data_out}, 8'hFF);

    lo_cyc = -1;
    for (int k = 0; k < 400 && lo_cyc < 0; k++) begin
      applyStimulus(0, 0);
      @(negedge clk);
      if (lights_out) lo_cyc = cyc;
    end
    checkOutput("model_v", m_v, 7'h59);
    checkOutput("lights_out_cycle", lo_cyc, 212);
    checkOutput("en_with_lights_out", {31'd0, fsm_en}, 1);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("fsm_s0_after_lights_out", ls, 0);
    repeat (35) applyStimulus(0, 0);
    applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("react_valid_pulse", {31'd0, react_valid}, 1);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("react_time_37", {16'd0, react_time}, 37);
    checkOutput("idle_after_react", {31'd0, busy}, 0);

    applyStimulus(1, 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      applyStimulus(0, 0);
      found = (ls == 4);
    end
    react = 1'b1;
    @(negedge clk);
    checkOutput("reached_s4", {31'd0, found}, 1);
    checkOutput("jump_start_pulse", {31'd0, jump_start}, 1);
    checkOutput("no_en_on_jump", {31'd0, fsm_en}, 0);
    cnt = 0; n = 0;
    do begin
      applyStimulus(0, 0);
      @(negedge clk);
      if (fsm_en) cnt++;
      n++;
    end while (busy && n < 30);
    checkOutput("abort_en_pulses", cnt, 5);
    checkOutput("abort_lights_s0", ls, 0);
    checkOutput("abort_returns_idle", {31'd0, busy}, 0);
    checkOutput("react_time_kept", {16'd0, react_time}, 37);

    applyStimulus(1, 1);
    @(negedge clk);
    checkOutput("start_with_react_trigger", {31'd0, fsm_trigger}, 1);
    checkOutput("start_with_react_no_jump", {31'd0, jump_start}, 0);
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("start_with_react_busy", {31'd0, busy}, 1);

    jumpy = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (k == 3000 || $urandom_range(0, 999) == 0) begin
        @(posedge clk);
        #1 rst = 1'b1; start = 1'b0; react = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      case (m_mode)
        M_IDLE: begin
          jumpy = ($urandom_range(0, 2) == 0);
          s = ($urandom_range(0, 7) == 0);
          r = ($urandom_range(0, 3) == 0);
        end
        M_TIMING: begin
          s = ($urandom_range(0, 9) == 0);
          r = ($urandom_range(0, 24) == 0);
        end
        M_ABORT: begin
          s = ($urandom_range(0, 1) == 0);
          r = ($urandom_range(0, 1) == 0);
        end
        default: begin
          s = ($urandom_range(0, 15) == 0);
          r = jumpy && ($urandom_range(0, 59) == 0);
        end
      endcase
      applyStimulus(s, r);
    end

    doReset();
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      found = lights_out4;
    end
    @(posedge clk);
    #1 react4 = 1'b1;
    @(negedge clk);
    checkOutput("sat_lights_out_seen", {31'd0, found}, 1);
    checkOutput("sat_react_valid", {31'd0, react_valid4}, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("sat_react_time_1", {28'd0, react_time4}, 1);
    checkOutput("sat_idle_after_react", {31'd0, busy4}, 0);
    @(posedge clk);
    #1 react4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      found = lights_out4;
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 start4 = (i % 3 == 0);
      @(negedge clk);
      if (fsm_trigger4 || !busy4 || react_valid4) bad++;
    end
    checkOutput("sat_timing_ignores_start", bad, 0);
    @(posedge clk);
    #1 start4 = 1'b0; react4 = 1'b1;
    @(posedge clk);
    #1 react4 = 1'b0;
    @(negedge clk);
    checkOutput("sat_react_time_15", {28'd0, react_time4}, 15);
    checkOutput("sat_idle_end", {31'd0, busy4}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
